// File: rtl/fpadd_rr_arbiter.sv
// fpadd_rr_arbiter
//   Round-robin scheduler sharing one multi-cycle floating-point add/sub unit
//   among NREQ requesters. One job is in flight at a time: the round-robin
//   winner is accepted in IDLE, launched in ISSUE, awaited in WAIT and its
//   result is returned to that requester only from RESP.
//
// Optional build macro:
//   FPADD_TIMEOUT_EN - adds a WAIT watchdog. After TIMEOUT cycles without
//                      fa_done the job completes with rsp_z=1, rsp_ovf=2'b11.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req[NREQ]         per-requester operation request
//   req_x/req_y       32-bit operands, requester i in bits [32i+31:32i]
//   req_sub[NREQ]     1 = x-y, 0 = x+y
//   gnt[NREQ]         one-hot accept pulse
//   rsp_valid[NREQ]   one-hot result-valid pulse
//   rsp_z, rsp_ovf    shared result bus and overflow code (held until next capture)
//   busy              high whenever the FSM is not in IDLE
//   fa_start          one-cycle launch pulse to the adder
//   fa_x, fa_y,fa_sub adder operands, stable from launch until the job ends
//   fa_done,fa_z,fa_ovf  adder completion pulse and result
//   dbg_state         current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
// Handshake: a requester holds req and its operands until it sees its gnt
// pulse and drops req no later than the cycle after. req is only sampled in
// IDLE, so a request still high during ISSUE/WAIT/RESP is never re-issued.
// The adder sees fa_start for one cycle and answers with a one-cycle fa_done
// at least one cycle later; fa_done is only honoured in WAIT.
module fpadd_rr_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64,
   parameter int PW      = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   req_x,
   input  logic [32*NREQ-1:0]   req_y,
   input  logic [NREQ-1:0]      req_sub,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_z,
   output logic [1:0]           rsp_ovf,
   output logic                 busy,
   output logic                 fa_start,
   output logic [31:0]          fa_x,
   output logic [31:0]          fa_y,
   output logic                 fa_sub,
   input  logic                 fa_done,
   input  logic [31:0]          fa_z,
   input  logic [1:0]           fa_ovf,
   output logic [1:0]           dbg_state
);

   localparam int RW  = 2**PW;
   localparam int PW1 = PW + 1;

   if (NREQ < 2 || NREQ > 8 || RW < NREQ || TIMEOUT < 2) begin : g_bad_params
      $error("fpadd_rr_arbiter: illegal NREQ/PW/TIMEOUT combination");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     winner_q, winner_d;
   logic [31:0]       fa_x_q, fa_x_d, fa_y_q, fa_y_d;
   logic              fa_sub_q, fa_sub_d;
   logic              fa_start_q, fa_start_d;
   logic [NREQ-1:0]   gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_z_q, rsp_z_d;
   logic [1:0]        rsp_ovf_q, rsp_ovf_d;
   logic              busy_q, busy_d;
`ifdef FPADD_TIMEOUT_EN
   logic [31:0]       tmo_cnt_q, tmo_cnt_d;
`endif

   // Arbitration helpers
   logic [RW-1:0]     req_pad;
   logic [PW:0]       cand_sum;
   logic              found;
   logic [PW-1:0]     pick;
   logic [NREQ-1:0]   pick_oh, win_oh;
   logic [31:0]       sel_x, sel_y;
   logic              sel_sub;

   always_comb begin
      // Round-robin scan: candidates ptr, ptr+1, ... wrapped modulo NREQ.
      // req is zero-extended to 2**PW bits so a PW-bit index is always in range.
      req_pad  = RW'(req);
      cand_sum = '0;
      found    = 1'b0;
      pick     = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_sum = {1'b0, ptr_q} + PW1'(k);
         if (cand_sum >= PW1'(NREQ)) cand_sum = cand_sum - PW1'(NREQ);
         if (!found && req_pad[cand_sum[PW-1:0]]) begin
            found = 1'b1;
            pick  = cand_sum[PW-1:0];
         end
      end

      sel_x   = '0;
      sel_y   = '0;
      sel_sub = 1'b0;
      pick_oh = '0;
      win_oh  = '0;
      for (int i = 0; i < NREQ; i++) begin
         pick_oh[i] = (pick == PW'(i));
         win_oh[i]  = (winner_q == PW'(i));
         if (pick == PW'(i)) begin
            sel_x   = req_x[32*i +: 32];
            sel_y   = req_y[32*i +: 32];
            sel_sub = req_sub[i];
         end
      end

      state_d     = state_q;
      ptr_d       = ptr_q;
      winner_d    = winner_q;
      fa_x_d      = fa_x_q;
      fa_y_d      = fa_y_q;
      fa_sub_d    = fa_sub_q;
      fa_start_d  = 1'b0;
      gnt_d       = '0;
      rsp_valid_d = '0;
      rsp_z_d     = rsp_z_q;
      rsp_ovf_d   = rsp_ovf_q;
`ifdef FPADD_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (found) begin
               winner_d = pick;
               fa_x_d   = sel_x;
               fa_y_d   = sel_y;
               fa_sub_d = sel_sub;
               gnt_d    = pick_oh;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            fa_start_d = 1'b1;
            state_d    = S_WAIT;
`ifdef FPADD_TIMEOUT_EN
            tmo_cnt_d  = '0;
`endif
         end
         S_WAIT: begin
            if (fa_done) begin
               rsp_z_d   = fa_z;
               rsp_ovf_d = fa_ovf;
               state_d   = S_RESP;
            end
`ifdef FPADD_TIMEOUT_EN
            // Watchdog: TIMEOUT cycles of WAIT without an answer.
            else if (tmo_cnt_q == 32'(TIMEOUT - 1)) begin
               rsp_z_d   = 32'h0000_0001;
               rsp_ovf_d = 2'b11;
               state_d   = S_RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
`endif
         end
         S_RESP: begin
            rsp_valid_d = win_oh;
            ptr_d       = (winner_q == PW'(NREQ - 1)) ? '0 : winner_q + 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Registered busy tracks the state register exactly.
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         winner_q    <= '0;
         fa_x_q      <= '0;
         fa_y_q      <= '0;
         fa_sub_q    <= 1'b0;
         fa_start_q  <= 1'b0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_z_q     <= '0;
         rsp_ovf_q   <= '0;
         busy_q      <= 1'b0;
`ifdef FPADD_TIMEOUT_EN
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         winner_q    <= winner_d;
         fa_x_q      <= fa_x_d;
         fa_y_q      <= fa_y_d;
         fa_sub_q    <= fa_sub_d;
         fa_start_q  <= fa_start_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_z_q     <= rsp_z_d;
         rsp_ovf_q   <= rsp_ovf_d;
         busy_q      <= busy_d;
`ifdef FPADD_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_z     = rsp_z_q;
   assign rsp_ovf   = rsp_ovf_q;
   assign busy      = busy_q;
   assign fa_start  = fa_start_q;
   assign fa_x      = fa_x_q;
   assign fa_y      = fa_y_q;
   assign fa_sub    = fa_sub_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fpadd_rr_arbiter.sv
// Bench for fpadd_rr_arbiter: behavioural adder model plus one task per
// scenario, each with its own inline comparisons.
`timescale 1ns/1ps
module tb_fpadd_rr_arbiter;

   localparam int NREQ    = 4;
   localparam int PW      = 3;
   localparam int TIMEOUT = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NREQ-1:0]    req = '0;
   logic [32*NREQ-1:0] req_x = '0;
   logic [32*NREQ-1:0] req_y = '0;
   logic [NREQ-1:0]    req_sub = '0;
   logic [NREQ-1:0]    gnt, rsp_valid;
   logic [31:0]        rsp_z, fa_x, fa_y;
   logic [1:0]         rsp_ovf, dbg_state;
   logic               busy, fa_start, fa_sub;
   logic               fa_done = 1'b0;
   logic [31:0]        fa_z = '0;
   logic [1:0]         fa_ovf = '0;

   int checks = 0;
   int errors = 0;
   logic [NREQ-1:0] exp_q[$];

   fpadd_rr_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .PW(PW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
      .req_sub(req_sub), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_z(rsp_z),
      .rsp_ovf(rsp_ovf), .busy(busy), .fa_start(fa_start), .fa_x(fa_x),
      .fa_y(fa_y), .fa_sub(fa_sub), .fa_done(fa_done), .fa_z(fa_z),
      .fa_ovf(fa_ovf), .dbg_state(dbg_state)
   );

   // ---------------- adder model ----------------
   // Answers ad_lat cycles after it sees fa_start (>= 1). With ad_sum set the
   // result is the integer sum of the operands so operand routing is visible.
   int          ad_cnt = 0;
   int          ad_lat = 1;
   logic        ad_en  = 1'b1;
   logic        ad_sum = 1'b0;
   logic [31:0] ad_z   = '0;
   logic [1:0]  ad_ovf = '0;
   logic        stray  = 1'b0;
   logic [31:0] pend_z = '0;
   logic [1:0]  pend_ovf = '0;

   always @(negedge clk) begin
      fa_done = 1'b0;
      if (stray) begin
         fa_done = 1'b1;
         fa_z    = 32'hDEAD_BEEF;
         fa_ovf  = 2'b11;
      end
      if (ad_cnt > 0) begin
         ad_cnt = ad_cnt - 1;
         if (ad_cnt == 0) begin
            fa_done = 1'b1;
            fa_z    = pend_z;
            fa_ovf  = pend_ovf;
         end
      end else if (fa_start && ad_en) begin
         ad_cnt   = ad_lat;
         pend_z   = ad_sum ? fa_x + fa_y : ad_z;
         pend_ovf = ad_sum ? 2'b00 : ad_ovf;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_watchdog: got no end of test, expected finish before 200us");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic set_op(input int idx, input logic [31:0] x, input logic [31:0] y,
                         input logic sub);
      req_x[32*idx +: 32] = x;
      req_y[32*idx +: 32] = y;
      req_sub[idx]        = sub;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Raises req=mask, waits for a grant, drops req, waits for the response.
   task automatic run_job(input logic [NREQ-1:0] mask, output logic [NREQ-1:0] g_seen,
                          output logic [NREQ-1:0] r_seen);
      int n;
      req = mask;
      n = 0;
      while (gnt === '0 && n < 20) begin @(negedge clk); n++; end
      g_seen = gnt;
      req = '0;
      n = 0;
      while (rsp_valid === '0 && n < 40) begin @(negedge clk); n++; end
      r_seen = rsp_valid;
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({gnt, rsp_valid, rsp_z, rsp_ovf, busy, fa_start, fa_x, fa_y, fa_sub, dbg_state} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got gnt=%b rv=%b z=%h ovf=%b busy=%b st=%b fx=%h fy=%h sub=%b state=%0d, expected all 0",
                  gnt, rsp_valid, rsp_z, rsp_ovf, busy, fa_start, fa_x, fa_y, fa_sub, dbg_state);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || dbg_state !== 2'd0 || gnt !== '0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b state=%0d gnt=%b, expected 0/0/0", busy, dbg_state, gnt);
      end
   endtask

   task automatic test_single();
      int n;
      ad_en = 1'b1; ad_sum = 1'b0; ad_lat = 5; ad_z = 32'h4040_0000; ad_ovf = 2'b00;
      set_op(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
      req = 4'b0001;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0001 || fa_start !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_gnt: got gnt=%b start=%b busy=%b, expected 0001/0/1", gnt, fa_start, busy);
      end
      req = '0;
      @(negedge clk);
      checks++;
      if (fa_start !== 1'b1 || gnt !== '0) begin
         errors++;
         $display("FAIL single_start: got start=%b gnt=%b, expected 1/0000", fa_start, gnt);
      end
      checks++;
      if ({fa_x, fa_y, fa_sub} !== {32'h3F80_0000, 32'h4000_0000, 1'b0}) begin
         errors++;
         $display("FAIL single_operands: got x=%h y=%h sub=%b, expected 3f800000 40000000 0", fa_x, fa_y, fa_sub);
      end
      n = 0;
      while (rsp_valid === '0 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (n != 7) begin
         errors++;
         $display("FAIL single_latency: got %0d cycles start->rsp_valid, expected 7", n);
      end
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_z !== 32'h4040_0000 || rsp_ovf !== 2'b00) begin
         errors++;
         $display("FAIL single_rsp: got rv=%b z=%h ovf=%b, expected 0001 40400000 00", rsp_valid, rsp_z, rsp_ovf);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0 || rsp_z !== 32'h4040_0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_hold: got rv=%b z=%h busy=%b, expected 0000 40400000 0", rsp_valid, rsp_z, busy);
      end
   endtask

   task automatic test_contention();
      logic [31:0] xs[NREQ];
      logic [31:0] ys[NREQ];
      logic [NREQ-1:0] exp;
      int n, idx, extra;
      for (int i = 0; i < NREQ; i++) begin
         xs[i] = $urandom_range(32'h00FF_FFFF, 0);
         ys[i] = $urandom_range(32'h00FF_FFFF, 0);
         set_op(i, xs[i], ys[i], i[0]);
      end
      exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      ad_en = 1'b1; ad_sum = 1'b1;
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         exp = exp_q.pop_front();
         idx = 0;
         for (int b = 0; b < NREQ; b++) if (exp[b]) idx = b;
         n = 0;
         while (gnt === '0 && n < 20) begin @(negedge clk); n++; end
         checks++;
         if (gnt !== exp) begin
            errors++;
            $display("FAIL contention_gnt job%0d: got %b, expected %b", j, gnt, exp);
         end
         if (j == 4) req = '0;
         ad_lat = $urandom_range(4, 1);
         @(negedge clk);
         checks++;
         if ({fa_x, fa_y, fa_sub} !== {xs[idx], ys[idx], idx[0]}) begin
            errors++;
            $display("FAIL contention_operands job%0d: got x=%h y=%h sub=%b, expected %h %h %b",
                     j, fa_x, fa_y, fa_sub, xs[idx], ys[idx], idx[0]);
         end
         extra = 0;
         n = 0;
         while (rsp_valid === '0 && n < 20) begin
            if (gnt !== '0) extra++;
            @(negedge clk);
            n++;
         end
         checks++;
         if (extra != 0) begin
            errors++;
            $display("FAIL contention_busy_gnt job%0d: got %0d extra grants, expected 0", j, extra);
         end
         checks++;
         if (rsp_valid !== exp || rsp_z !== xs[idx] + ys[idx]) begin
            errors++;
            $display("FAIL contention_rsp job%0d: got rv=%b z=%h, expected %b %h",
                     j, rsp_valid, rsp_z, exp, xs[idx] + ys[idx]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_sub_ovf();
      int n;
      ad_en = 1'b1; ad_sum = 1'b0; ad_lat = 3; ad_z = 32'h7F80_0000; ad_ovf = 2'b01;
      set_op(2, 32'h7F00_0000, 32'hFF00_0000, 1'b1);
      req = 4'b0100;
      n = 0;
      while (gnt === '0 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (gnt !== 4'b0100) begin
         errors++;
         $display("FAIL sub_gnt: got %b, expected 0100", gnt);
      end
      req = '0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         checks++;
         if (fa_sub !== 1'b1) begin
            errors++;
            $display("FAIL sub_hold cycle%0d: got fa_sub=%b, expected 1", n, fa_sub);
         end
      end while (rsp_valid === '0 && n < 20);
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_ovf !== 2'b01 || rsp_z !== 32'h7F80_0000) begin
         errors++;
         $display("FAIL sub_rsp: got rv=%b ovf=%b z=%h, expected 0100 01 7f800000", rsp_valid, rsp_ovf, rsp_z);
      end
      @(negedge clk);
   endtask

   task automatic test_stray();
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== '0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL stray_done cycle%0d: got rv=%b busy=%b state=%0d, expected 0000 0 0",
                     c, rsp_valid, busy, dbg_state);
         end
      end
      checks++;
      if (rsp_z !== 32'h7F80_0000 || rsp_ovf !== 2'b01) begin
         errors++;
         $display("FAIL stray_result: got z=%h ovf=%b, expected 7f800000 01", rsp_z, rsp_ovf);
      end
   endtask

   task automatic test_reset_wait();
      int n;
      logic [NREQ-1:0] g, r;
      ad_en = 1'b1; ad_sum = 1'b0; ad_lat = 6; ad_z = 32'h1234_5678; ad_ovf = 2'b10;
      set_op(1, 32'h4000_0000, 32'h4000_0000, 1'b0);
      req = 4'b0010;
      n = 0;
      while (gnt === '0 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("FAIL rstwait_gnt: got %b, expected 0010", gnt);
      end
      req = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (dbg_state !== 2'd2) begin
         errors++;
         $display("FAIL rstwait_in_wait: got state %0d, expected 2", dbg_state);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         checks++;
         if ({gnt, rsp_valid, rsp_z, rsp_ovf, busy, fa_start, fa_x, fa_y, fa_sub} !== '0) begin
            errors++;
            $display("FAIL rstwait_quiet cycle%0d: got gnt=%b rv=%b z=%h ovf=%b busy=%b st=%b, expected all 0",
                     c, gnt, rsp_valid, rsp_z, rsp_ovf, busy, fa_start);
         end
         @(negedge clk);
      end
      ad_lat = 2;
      set_op(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
      set_op(3, 32'hC000_0000, 32'h3F80_0000, 1'b1);
      run_job(4'b1001, g, r);
      checks++;
      if (g !== 4'b0001 || r !== 4'b0001) begin
         errors++;
         $display("FAIL rstwait_ptr0: got gnt=%b rv=%b, expected 0001 0001", g, r);
      end
      run_job(4'b1000, g, r);
      checks++;
      if (g !== 4'b1000 || r !== 4'b1000 || rsp_z !== 32'h1234_5678 || rsp_ovf !== 2'b10) begin
         errors++;
         $display("FAIL rstwait_winner3: got gnt=%b rv=%b z=%h ovf=%b, expected 1000 1000 12345678 10",
                  g, r, rsp_z, rsp_ovf);
      end
      run_job(4'b1001, g, r);
      checks++;
      if (g !== 4'b0001 || r !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_ptr: got gnt=%b rv=%b, expected 0001 0001", g, r);
      end
   endtask

`ifdef FPADD_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      ad_en = 1'b0;
      req = 4'b0001;
      n = 0;
      while (gnt === '0 && n < 20) begin @(negedge clk); n++; end
      req = '0;
      n = 0;
      while (rsp_valid === '0 && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (n != 10) begin
         errors++;
         $display("FAIL timeout_latency: got %0d cycles gnt->rsp_valid, expected 10", n);
      end
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_z !== 32'h0000_0001 || rsp_ovf !== 2'b11) begin
         errors++;
         $display("FAIL timeout_rsp: got rv=%b z=%h ovf=%b, expected 0001 00000001 11", rsp_valid, rsp_z, rsp_ovf);
      end
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_late_done: got rv=%b busy=%b, expected 0000 0", rsp_valid, busy);
      end
      ad_en = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      do_reset();
      test_contention();
      test_sub_ovf();
      test_stray();
      test_reset_wait();
`ifdef FPADD_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
